// File: rtl/yacht_pkg.sv
// Shared constants, category indices and score_board FSM encoding for Yacht Dice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package yacht_pkg;

    localparam int NUM_CAT         = 12;
    localparam int MAX_POINTS      = 50;
    localparam int BONUS_THRESHOLD = 63;
    localparam int BONUS_POINTS    = 35;

    // Twelve rounds per game; each round is one P1 and one P2 commit.
    localparam logic [3:0] LAST_ROUND = 4'd12;

    // Upper section
    localparam logic [3:0] CAT_ONES           = 4'd0;
    localparam logic [3:0] CAT_TWOS           = 4'd1;
    localparam logic [3:0] CAT_THREES         = 4'd2;
    localparam logic [3:0] CAT_FOURS          = 4'd3;
    localparam logic [3:0] CAT_FIVES          = 4'd4;
    localparam logic [3:0] CAT_SIXES          = 4'd5;
    // Lower section
    localparam logic [3:0] CAT_CHOICE         = 4'd6;
    localparam logic [3:0] CAT_FOUR_KIND      = 4'd7;
    localparam logic [3:0] CAT_FULL_HOUSE     = 4'd8;
    localparam logic [3:0] CAT_SMALL_STRAIGHT = 4'd9;
    localparam logic [3:0] CAT_LARGE_STRAIGHT = 4'd10;
    localparam logic [3:0] CAT_YACHT          = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_UPDATE = 3'd2,
        ST_BONUS  = 3'd3,
        ST_DONE   = 3'd4
    } sb_state_t;

    function automatic logic cat_in_range(input logic [3:0] cat);
        return int'(cat) < NUM_CAT;
    endfunction

    function automatic logic cat_is_upper(input logic [3:0] cat);
        return cat <= CAT_SIXES;
    endfunction

endpackage

// File: rtl/score_board_if.sv
// Commit handshake between the game FSM (master) and the score board (slave).
// Latency: n/a (wires only).
// Backpressure: master holds commit_valid until commit_ready is seen high on a clock edge.
//
// commit_valid/player/cat/pts : request from game FSM
// commit_ready                : score board can accept a request this cycle
// commit_done/commit_err      : one-cycle completion pulse, err qualifies a rejection
interface score_board_if;
    logic       commit_valid;
    logic       commit_ready;
    logic       commit_player;
    logic [3:0] commit_cat;
    logic [5:0] commit_pts;
    logic       commit_done;
    logic       commit_err;

    modport master (
        output commit_valid, commit_player, commit_cat, commit_pts,
        input  commit_ready, commit_done, commit_err
    );

    modport slave (
        input  commit_valid, commit_player, commit_cat, commit_pts,
        output commit_ready, commit_done, commit_err
    );
endinterface

// File: rtl/category_table.sv
// Per-player category point table (2 x NUM_CAT x 6 bit) with used bitmaps.
// Latency: write visible on the edge after wr_en; reads are combinational.
// Backpressure: none, one write port accepted every cycle.
//
// clear            : synchronous clear of table and bitmaps (reset or new game)
// wr_*             : single write port, out-of-range categories are ignored
// rd_*             : combinational lookup of one entry and its used bit
// p1_used/p2_used  : registered used bitmaps
module category_table
    import yacht_pkg::*;
(
    input  logic               clk,
    input  logic               clear,
    input  logic               wr_en,
    input  logic               wr_player,
    input  logic [3:0]         wr_cat,
    input  logic [5:0]         wr_pts,
    input  logic               rd_player,
    input  logic [3:0]         rd_cat,
    output logic               rd_used,
    output logic [5:0]         rd_pts,
    output logic [NUM_CAT-1:0] p1_used,
    output logic [NUM_CAT-1:0] p2_used
);

    logic [5:0]         tbl      [2][NUM_CAT];
    logic [NUM_CAT-1:0] used_map [2];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int p = 0; p < 2; p++) begin
                used_map[p] <= '0;
                for (int c = 0; c < NUM_CAT; c++) begin
                    tbl[p][c] <= '0;
                end
            end
        end else if (wr_en && cat_in_range(wr_cat)) begin
            tbl[wr_player][wr_cat]      <= wr_pts;
            used_map[wr_player][wr_cat] <= 1'b1;
        end
    end

    // Categories 12..15 do not exist: report them as unused with zero points
    // so the caller's range check is the only thing that rejects them.
    always_comb begin
        rd_used = 1'b0;
        rd_pts  = '0;
        if (cat_in_range(rd_cat)) begin
            rd_used = used_map[rd_player][rd_cat];
            rd_pts  = tbl[rd_player][rd_cat];
        end
    end

    assign p1_used = used_map[0];
    assign p2_used = used_map[1];

endmodule

// File: rtl/score_board.sv
// Yacht Dice score bookkeeping: checks one category commit per turn and keeps totals, bonus, turn and round.
// Latency: accepted commit done 4 cycles after acceptance, rejected commit done 2 cycles after.
// Backpressure: commit_ready is low from the cycle after acceptance until DONE exits, and while new_game is high.
//
// clk, reset_n        : clock, synchronous active-low reset
// new_game            : synchronous clear, same effect as reset
// cif (slave)         : commit request/ready/done/err handshake
// p1_score, p2_score  : 9-bit totals including bonus
// p1_used, p2_used    : category-used bitmaps
// turn, round_num     : next player to commit, current round 1..12
// game_over           : set when P2 completes round 12
module score_board
    import yacht_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               new_game,
    score_board_if.slave       cif,
    output logic [8:0]         p1_score,
    output logic [8:0]         p2_score,
    output logic [NUM_CAT-1:0] p1_used,
    output logic [NUM_CAT-1:0] p2_used,
    output logic               turn,
    output logic [3:0]         round_num,
    output logic               game_over
);

    sb_state_t  state;
    sb_state_t  state_nxt;

    logic       clr;
    logic       accept;
    logic       reject;

    logic       lat_player;
    logic [3:0] lat_cat;
    logic [5:0] lat_pts;

    logic [8:0] score_q [2];
    logic [6:0] upper_q [2];
    logic [1:0] bonus_q;

    logic       done_q;
    logic       err_q;

    logic       rd_used;
    logic [5:0] rd_pts;

    assign clr    = !reset_n || new_game;
    assign cif.commit_ready = (state == ST_IDLE) && !new_game;
    assign accept = cif.commit_valid && cif.commit_ready;

    category_table u_table (
        .clk       (clk),
        .clear     (clr),
        .wr_en     (state == ST_UPDATE),
        .wr_player (lat_player),
        .wr_cat    (lat_cat),
        .wr_pts    (lat_pts),
        .rd_player (lat_player),
        .rd_cat    (lat_cat),
        .rd_used   (rd_used),
        .rd_pts    (rd_pts),
        .p1_used   (p1_used),
        .p2_used   (p2_used)
    );

    // Legality of the latched commit; only consulted while in CHECK.
    assign reject = (lat_player != turn)
                 || !cat_in_range(lat_cat)
                 || (int'(lat_pts) > MAX_POINTS)
                 || rd_used
                 || game_over;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = reject ? ST_DONE : ST_UPDATE;
            ST_UPDATE: state_nxt = ST_BONUS;
            ST_BONUS:  state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= ST_IDLE;
            lat_player <= 1'b0;
            lat_cat    <= '0;
            lat_pts    <= '0;
            score_q[0] <= '0;
            score_q[1] <= '0;
            upper_q[0] <= '0;
            upper_q[1] <= '0;
            bonus_q    <= '0;
            turn       <= 1'b0;
            round_num  <= 4'd1;
            game_over  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state  <= state_nxt;
            // done/err are registered so they are high exactly while in DONE.
            done_q <= (state_nxt == ST_DONE);
            err_q  <= (state == ST_CHECK) && reject;

            if (accept) begin
                lat_player <= cif.commit_player;
                lat_cat    <= cif.commit_cat;
                lat_pts    <= cif.commit_pts;
            end

            case (state)
                ST_UPDATE: begin
                    score_q[lat_player] <= score_q[lat_player] + 9'(lat_pts);
                    if (cat_is_upper(lat_cat)) begin
                        upper_q[lat_player] <= upper_q[lat_player] + 7'(lat_pts);
                    end
                end
                ST_BONUS: begin
                    if (int'(upper_q[lat_player]) >= BONUS_THRESHOLD && !bonus_q[lat_player]) begin
                        score_q[lat_player] <= score_q[lat_player] + 9'(BONUS_POINTS);
                        bonus_q[lat_player] <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // err_q is high during DONE only for a rejected commit.
                    if (!err_q) begin
                        turn <= ~turn;
                        if (lat_player) begin
                            if (round_num == LAST_ROUND) begin
                                game_over <= 1'b1;
                            end else begin
                                round_num <= round_num + 4'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A category whose used bit is clear has never been written since the last clear.
    always_ff @(posedge clk) begin
        if (reset_n && !new_game && state == ST_CHECK && !rd_used) begin
            assert (rd_pts == '0);
        end
    end

    assign cif.commit_done = done_q;
    assign cif.commit_err  = err_q;
    assign p1_score        = score_q[0];
    assign p2_score        = score_q[1];

endmodule
